// File: rtl/stack_drain_reader.sv
// stack_drain_reader: read-side controller for a 12-bit, 8-deep LIFO stack.
// It takes producer pushes while idle. On drain_start it pops every stored
// entry, one pop at a time, and streams the words out newest-first.
// Ports:
//   clk, reset                       clock and asynchronous active-high reset
//   wr_req, wr_data, wr_accept       producer push side
//   drain_start                      single-cycle drain command
//   stk_pushenbl, stk_pushdatain     push enable and push data to the stack
//   stk_popenbl                      pop enable to the stack
//   stk_popdataout, stk_full         pop data and full flag from the stack
//   rd_valid, rd_ready, rd_data,     valid/ready output stream; rd_last marks
//   rd_last                          the oldest (final) word
//   drain_done, busy, count          status outputs
module stack_drain_reader #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_accept,
  input  logic              drain_start,
  output logic              stk_pushenbl,
  output logic              stk_popenbl,
  output logic [DATA_W-1:0] stk_pushdatain,
  input  logic [DATA_W-1:0] stk_popdataout,
  input  logic              stk_full,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              drain_done,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid, r_rd_last, r_drain_done;
  logic              w_idle, w_start, w_empty_start, w_handshake;
  assign w_idle         = r_state == IDLE;
  assign wr_accept      = wr_req & w_idle & (r_count < CNT_W'(DEPTH)) & ~stk_full;
  assign stk_pushenbl   = wr_accept;
  assign stk_pushdatain = wr_data;
  assign stk_popenbl    = r_state == ISSUE;
  // A push in the same cycle as drain_start lands first, so it counts as an entry.
  assign w_start        = w_idle & drain_start & ((r_count != '0) | wr_accept);
  assign w_empty_start  = w_idle & drain_start & (r_count == '0) & ~wr_accept;
  assign w_handshake    = r_rd_valid & rd_ready;
  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_data;
  assign rd_last        = r_rd_last;
  assign drain_done     = r_drain_done;
  assign busy           = ~w_idle;
  assign count          = r_count;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = OUT;
      OUT:     w_next = w_handshake ? (r_rd_last ? IDLE : ISSUE) : OUT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_drain_done <= w_empty_start | (w_handshake & r_rd_last);
      if (wr_accept)        r_count <= r_count + CNT_W'(1);
      else if (stk_popenbl) r_count <= r_count - CNT_W'(1);
      // Stack data is valid the cycle after the pop. By then count has already
      // been decremented, so zero means this word is the oldest one.
      if (r_state == WAIT) begin
        r_rd_data  <= stk_popdataout;
        r_rd_valid <= 1'b1;
        r_rd_last  <= r_count == '0;
      end else if (w_handshake) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stack_drain_reader.sv
// tb_stack_drain_reader: randomized scoreboard bench with a LIFO stack model
module tb_stack_drain_reader;
  logic        clk, reset, wr_req, wr_accept, drain_start;
  logic        stk_pushenbl, stk_popenbl, stk_full, rd_valid, rd_ready, rd_last;
  logic        drain_done, busy, force_full;
  logic [11:0] wr_data, stk_pushdatain, stk_popdataout, rd_data;
  logic [3:0]  count;
  typedef struct {logic [11:0] d; logic last;} exp_t;
  exp_t        exp_q[$];
  logic [11:0] ref_q[$];
  logic [11:0] stk_q[$];
  int          stk_n, cyc, exp_done_cyc, total, bad;
  bit          draining, pv, pr, pl;
  logic [11:0] pd;

  stack_drain_reader dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_accept(wr_accept),
    .drain_start(drain_start), .stk_pushenbl(stk_pushenbl), .stk_popenbl(stk_popenbl),
    .stk_pushdatain(stk_pushdatain), .stk_popdataout(stk_popdataout), .stk_full(stk_full),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .drain_done(drain_done), .busy(busy), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign stk_full = force_full || (stk_n == 8);
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_q.delete();
      stk_n <= 0;
      stk_popdataout <= '0;
    end else begin
      if (stk_pushenbl) stk_q.push_back(stk_pushdatain);
      if (stk_popenbl && stk_q.size() > 0) stk_popdataout <= stk_q.pop_back();
      stk_n <= stk_n + int'(stk_pushenbl) - int'(stk_popenbl && stk_n > 0);
    end
  end

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", int'(rd_valid), 1);
        chk("hold_data", int'(rd_data), int'(pd));
        chk("hold_last", int'(rd_last), int'(pl));
      end
      if (stk_popenbl) begin
        chk("pop_in_drain", int'(draining), 1);
        chk("pop_single", int'(rd_valid), 0);
      end
      if (rd_valid) chk("valid_in_drain", int'(draining), 1);
      if (drain_done || cyc == exp_done_cyc) chk("drain_done", int'(drain_done), int'(cyc == exp_done_cyc));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %0h want none", rd_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_data", int'(rd_data), int'(e.d));
          chk("rd_last", int'(rd_last), int'(e.last));
          if (e.last) begin
            draining = 0;
            exp_done_cyc = cyc + 1;
          end
        end
      end
      pv = rd_valid; pd = rd_data; pl = rd_last; pr = rd_ready;
    end
  end

  task automatic step(input logic wq, input logic [11:0] wd, input logic ds, input logic rr, input logic ff);
    bit acc;
    @(posedge clk); #1;
    wr_req = wq; wr_data = wd; drain_start = ds; rd_ready = rr; force_full = ff;
    #2;
    acc = wq && !draining && ref_q.size() < 8 && !ff;
    chk("wr_accept", int'(wr_accept), int'(acc));
    chk("pushenbl", int'(stk_pushenbl), int'(acc));
    if (acc) chk("pushdata", int'(stk_pushdatain), int'(wd));
    chk("busy", int'(busy), int'(draining));
    if (!draining) chk("count", int'(count), ref_q.size());
    if (acc) ref_q.push_back(wd);
    if (ds && !draining) begin
      if (ref_q.size() > 0) begin
        draining = 1;
        while (ref_q.size() > 0) begin
          exp_t e;
          e.d = ref_q.pop_back();
          e.last = ref_q.size() == 0;
          exp_q.push_back(e);
        end
      end else exp_done_cyc = cyc + 1;
    end
  endtask

  task automatic wait_drain(input bit rand_ready);
    int n = 0;
    while ((draining || exp_q.size() > 0) && n < 200) begin
      step(0, 12'h0, 0, rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 0);
      n++;
    end
    if (draining) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d words pending want 0", exp_q.size());
    end
    step(0, 12'h0, 0, 1, 0);
    step(0, 12'h0, 0, 1, 0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0; draining = 0; exp_done_cyc = -1;
    reset = 1; wr_req = 0; wr_data = 0; drain_start = 0; rd_ready = 0; force_full = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_last", int'(rd_last), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_drain_done", int'(drain_done), 0);
    chk("rst_popenbl", int'(stk_popenbl), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1 reset = 0;

    step(1, 12'h111, 0, 1, 0);
    step(1, 12'h222, 0, 1, 0);
    step(1, 12'h333, 0, 1, 0);
    step(0, 12'h0, 1, 1, 0);
    wait_drain(0);

    for (int i = 0; i < 8; i++) step(1, 12'($urandom), 0, 1, 0);
    step(1, 12'hABC, 0, 1, 0);
    step(1, 12'h5A5, 0, 1, 1);
    step(0, 12'h0, 1, 0, 0);
    n = 0;
    while (!rd_valid && n < 20) begin step(0, 12'h0, 0, 0, 0); n++; end
    if (!rd_valid) begin
      total++; bad++;
      $display("FAIL first_word_timeout: got rd_valid=0 want 1");
    end
    repeat (5) step(1, 12'($urandom), 1, 0, 0);
    wait_drain(0);

    step(0, 12'h0, 1, 1, 0);
    step(0, 12'h0, 0, 1, 0);
    step(0, 12'h0, 0, 1, 0);

    step(1, 12'h0F0, 0, 1, 0);
    step(1, 12'h7E7, 1, 1, 0);
    wait_drain(0);

    step(1, 12'hA01, 0, 1, 0);
    step(1, 12'hA02, 0, 1, 0);
    step(1, 12'hA03, 0, 1, 0);
    step(0, 12'h0, 1, 1, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1; drain_start = 0;
    #1;
    chk("rstmid_rd_valid", int'(rd_valid), 0);
    chk("rstmid_count", int'(count), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_popenbl", int'(stk_popenbl), 0);
    ref_q.delete(); exp_q.delete(); draining = 0; exp_done_cyc = -1;
    @(posedge clk); #1 reset = 0;
    step(1, 12'hB01, 0, 1, 0);
    step(1, 12'hB02, 0, 1, 0);
    step(0, 12'h0, 1, 1, 0);
    wait_drain(0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, 12'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    wait_drain(1);
    step(0, 12'h0, 1, 1, 0);
    wait_drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
